// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU control: operation codes, ALUOp classes, funct7 patterns.
// Latency: n/a (constants and a pure decode helper).
// Backpressure: n/a.
package alu_pkg;

    // 4-bit operation codes reported on ALUCtrl_o
    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_SLL     = 4'b0011;
    localparam logic [3:0] ALU_XOR     = 4'b0100;
    localparam logic [3:0] ALU_SRL     = 4'b0101;
    localparam logic [3:0] ALU_SUB     = 4'b0110;
    localparam logic [3:0] ALU_MUL     = 4'b0111;
    localparam logic [3:0] ALU_SRA     = 4'b1000;
    localparam logic [3:0] ALU_SLT     = 4'b1001;
    localparam logic [3:0] ALU_SLTU    = 4'b1010;
    localparam logic [3:0] ALU_DIV     = 4'b1011;
    localparam logic [3:0] ALU_DIVU    = 4'b1100;
    localparam logic [3:0] ALU_REM     = 4'b1101;
    localparam logic [3:0] ALU_REMU    = 4'b1110;
    localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

    // ALUOp classes from the main decoder
    localparam logic [1:0] ALUOP_LS = 2'b00;
    localparam logic [1:0] ALUOP_BR = 2'b01;
    localparam logic [1:0] ALUOP_R  = 2'b10;
    localparam logic [1:0] ALUOP_I  = 2'b11;

    // funct7 patterns
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    // funct3 -> code for the base integer group (funct7 = 0000000)
    function automatic logic [3:0] base_code(input logic [2:0] f3);
        logic [3:0] code;
        code = ALU_ILLEGAL;
        case (f3)
            3'b000: code = ALU_ADD;
            3'b001: code = ALU_SLL;
            3'b010: code = ALU_SLT;
            3'b011: code = ALU_SLTU;
            3'b100: code = ALU_XOR;
            3'b101: code = ALU_SRL;
            3'b110: code = ALU_OR;
            3'b111: code = ALU_AND;
            default: code = ALU_ILLEGAL;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative radix-2 multiply (shift-add) and restoring divide with final sign fix-up.
// Latency: XLEN steps after start_i; done_o is asserted combinationally during the last step.
// Backpressure: none internally; busy_o tells the owner not to start again, flush_i abandons the op.
//
// Ports: clk_i/rst_i (sync, active-low); start_i with is_div_i/is_signed_i/want_rem_i and
// operands a_i/b_i; flush_i kills the running op; busy_o, done_o, result_o (valid with done_o).
module alu_iter_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic            is_div_i,
    input  logic            is_signed_i,
    input  logic            want_rem_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam int CW = $clog2(XLEN) + 1;

    // acc: product (mul) or partial remainder (div)
    // opa: shifted multiplicand (mul) or dividend shifting into quotient (div)
    // opb: shifted multiplier (mul) or divisor magnitude (div)
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] opa_q, opa_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic            is_div_q, is_div_d;
    logic            want_rem_q, want_rem_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;

    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   r_sh, r_sub;
    logic            div_ge;

    assign busy_o = (cnt_q != '0);
    assign done_o = busy_o && (cnt_q == CW'(1)) && !flush_i;

    always_comb begin
        a_neg = is_signed_i && a_i[XLEN-1];
        b_neg = is_signed_i && b_i[XLEN-1];
        a_mag = a_neg ? -a_i : a_i;
        b_mag = b_neg ? -b_i : b_i;

        // restoring step: bring down the next dividend bit, subtract if it fits
        r_sh   = {acc_q, opa_q[XLEN-1]};
        div_ge = (r_sh >= {1'b0, opb_q});
        r_sub  = r_sh - {1'b0, opb_q};

        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        is_div_d   = is_div_q;
        want_rem_d = want_rem_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;

        if (flush_i) begin
            cnt_d = '0;
        end else if (start_i) begin
            cnt_d      = CW'(XLEN);
            acc_d      = '0;
            opa_d      = is_div_i ? a_mag : a_i;
            opb_d      = is_div_i ? b_mag : b_i;
            is_div_d   = is_div_i;
            want_rem_d = want_rem_i;
            neg_quo_d  = is_div_i && (a_neg ^ b_neg);
            neg_rem_d  = is_div_i && a_neg;
        end else if (busy_o) begin
            cnt_d = cnt_q - CW'(1);
            if (is_div_q) begin
                acc_d = div_ge ? r_sub[XLEN-1:0] : r_sh[XLEN-1:0];
                opa_d = {opa_q[XLEN-2:0], div_ge};
            end else begin
                acc_d = acc_q + (opb_q[0] ? opa_q : '0);
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
            end
        end
    end

    // Result is taken from the step being computed now, so the sign fix-up
    // rides on the final iteration instead of costing an extra cycle.
    always_comb begin
        result_o = acc_d;
        if (is_div_q) begin
            if (want_rem_q) result_o = neg_rem_q ? -acc_d : acc_d;
            else            result_o = neg_quo_q ? -opa_d : opa_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            is_div_q   <= 1'b0;
            want_rem_q <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            is_div_q   <= is_div_d;
            want_rem_q <= want_rem_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
        end
    end

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// EX-stage ALU control: decode, single-cycle RV32I ALU, iterative M-extension ops, registered outputs.
// Latency: 1 cycle for single-cycle/illegal/division special cases, XLEN+1 for MUL/DIV/REM.
// Backpressure: stall_o high while iterating; valid_i seen while busy is dropped.
//
// Ports: clk_i/rst_i (sync, active-low); valid_i/flush_i; ALUOp_i/funct3_i/funct7_i decode inputs;
// rs1_i/rs2_i operands; stall_o busy; valid_o one-cycle completion pulse with result_o/ALUCtrl_o/illegal_o.
module alu_ctrl_muldiv
    import alu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic            flush_i,
    input  logic [1:0]      ALUOp_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            stall_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [3:0]      ALUCtrl_o,
    output logic            illegal_o
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_q, state_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [3:0]      ctrl_q, ctrl_d;
    logic            illegal_q, illegal_d;
    logic [3:0]      busy_code_q, busy_code_d;

    logic [3:0]      dec_code;
    logic [XLEN-1:0] alu_res;
    logic [SHW-1:0]  shamt;
    logic            div_zero, div_ovf, is_divrem, is_iter;
    logic            accept, start;
    logic            iter_busy, iter_done;
    logic [XLEN-1:0] iter_res;

    // ---------------- decode ----------------
    always_comb begin
        dec_code = ALU_ILLEGAL;
        unique case (ALUOp_i)
            ALUOP_LS: dec_code = ALU_ADD;
            ALUOP_BR: dec_code = ALU_SUB;
            ALUOP_R: begin
                if (funct7_i == F7_BASE) begin
                    dec_code = base_code(funct3_i);
                end else if (funct7_i == F7_ALT) begin
                    if (funct3_i == 3'b000)      dec_code = ALU_SUB;
                    else if (funct3_i == 3'b101) dec_code = ALU_SRA;
                end else if ((funct7_i == F7_MULDIV) && ENABLE_M) begin
                    case (funct3_i)
                        3'b000:  dec_code = ALU_MUL;
                        3'b100:  dec_code = ALU_DIV;
                        3'b101:  dec_code = ALU_DIVU;
                        3'b110:  dec_code = ALU_REM;
                        3'b111:  dec_code = ALU_REMU;
                        default: dec_code = ALU_ILLEGAL;
                    endcase
                end
            end
            ALUOP_I: begin
                // funct7 is immediate bits except on the shift encodings
                if (funct3_i == 3'b001) begin
                    if (funct7_i == F7_BASE) dec_code = ALU_SLL;
                end else if (funct3_i == 3'b101) begin
                    if (funct7_i == F7_BASE)     dec_code = ALU_SRL;
                    else if (funct7_i == F7_ALT) dec_code = ALU_SRA;
                end else begin
                    dec_code = base_code(funct3_i);
                end
            end
        endcase
    end

    // ---------------- single-cycle ALU and division special cases ----------------
    assign shamt     = rs2_i[SHW-1:0];
    assign div_zero  = (rs2_i == '0);
    assign div_ovf   = (rs1_i == MOST_NEG) && (rs2_i == '1);
    assign is_divrem = (dec_code == ALU_DIV) || (dec_code == ALU_DIVU) ||
                       (dec_code == ALU_REM) || (dec_code == ALU_REMU);
    // signed overflow only matters for the signed pair
    assign is_iter   = (dec_code == ALU_MUL) ||
                       (is_divrem && !div_zero &&
                        !(div_ovf && ((dec_code == ALU_DIV) || (dec_code == ALU_REM))));

    always_comb begin
        alu_res = '0;
        case (dec_code)
            ALU_AND:  alu_res = rs1_i & rs2_i;
            ALU_OR:   alu_res = rs1_i | rs2_i;
            ALU_ADD:  alu_res = rs1_i + rs2_i;
            ALU_SLL:  alu_res = rs1_i << shamt;
            ALU_XOR:  alu_res = rs1_i ^ rs2_i;
            ALU_SRL:  alu_res = rs1_i >> shamt;
            ALU_SUB:  alu_res = rs1_i - rs2_i;
            ALU_SRA:  alu_res = $unsigned($signed(rs1_i) >>> shamt);
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(rs1_i) < $signed(rs2_i))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (rs1_i < rs2_i)};
            // only consumed when the division is a special case
            ALU_DIV:  alu_res = div_zero ? '1 : MOST_NEG;
            ALU_DIVU: alu_res = '1;
            ALU_REM:  alu_res = div_zero ? rs1_i : '0;
            ALU_REMU: alu_res = rs1_i;
            default:  alu_res = '0;
        endcase
    end

    // ---------------- FSM ----------------
    assign accept = (state_q == ST_IDLE) && valid_i && !flush_i;

    always_ff @(posedge clk_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept && is_iter)       state_d = ST_BUSY;
            ST_BUSY: if (flush_i || iter_done)    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_o = (state_q == ST_BUSY);
        start   = accept && is_iter;
    end

    alu_iter_muldiv #(.XLEN(XLEN)) u_iter (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start),
        .flush_i     (flush_i),
        .is_div_i    (dec_code != ALU_MUL),
        .is_signed_i ((dec_code == ALU_DIV) || (dec_code == ALU_REM)),
        .want_rem_i  ((dec_code == ALU_REM) || (dec_code == ALU_REMU)),
        .a_i         (rs1_i),
        .b_i         (rs2_i),
        .busy_o      (iter_busy),
        .done_o      (iter_done),
        .result_o    (iter_res)
    );

    // ---------------- output registers ----------------
    // result/ctrl hold between completions; valid is a single-cycle pulse
    always_comb begin
        valid_d     = 1'b0;
        result_d    = result_q;
        ctrl_d      = ctrl_q;
        illegal_d   = illegal_q;
        busy_code_d = busy_code_q;
        if (accept && !is_iter) begin
            valid_d   = 1'b1;
            result_d  = alu_res;
            ctrl_d    = dec_code;
            illegal_d = (dec_code == ALU_ILLEGAL);
        end
        if (start) begin
            busy_code_d = dec_code;
        end
        if ((state_q == ST_BUSY) && iter_busy && iter_done) begin
            valid_d   = 1'b1;
            result_d  = iter_res;
            ctrl_d    = busy_code_q;
            illegal_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_q     <= 1'b0;
            result_q    <= '0;
            ctrl_q      <= ALU_AND;
            illegal_q   <= 1'b0;
            busy_code_q <= ALU_AND;
        end else begin
            valid_q     <= valid_d;
            result_q    <= result_d;
            ctrl_q      <= ctrl_d;
            illegal_q   <= illegal_d;
            busy_code_q <= busy_code_d;
        end
    end

    assign valid_o   = valid_q;
    assign result_o  = result_q;
    assign ALUCtrl_o = ctrl_q;
    assign illegal_o = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Directed self-checking bench for alu_ctrl_muldiv (XLEN=32, ENABLE_M=1).
// Latency: inputs driven 1 ns after a rising edge, outputs sampled 1 ns after the next one.
// Backpressure: stall windows are walked cycle by cycle with fixed budgets.
module tb_alu_ctrl_muldiv;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [1:0]  ALUOp_i = 2'b00;
    logic [2:0]  funct3_i = 3'b000;
    logic [6:0]  funct7_i = 7'b0000000;
    logic [31:0] rs1_i = 32'd0;
    logic [31:0] rs2_i = 32'd0;
    logic        stall_o;
    logic        valid_o;
    logic [31:0] result_o;
    logic [3:0]  ALUCtrl_o;
    logic        illegal_o;

    int total  = 0;
    int passed = 0;

    alu_ctrl_muldiv #(.XLEN(32), .ENABLE_M(1'b1)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .flush_i   (flush_i),
        .ALUOp_i   (ALUOp_i),
        .funct3_i  (funct3_i),
        .funct7_i  (funct7_i),
        .rs1_i     (rs1_i),
        .rs2_i     (rs2_i),
        .stall_o   (stall_o),
        .valid_o   (valid_o),
        .result_o  (result_o),
        .ALUCtrl_o (ALUCtrl_o),
        .illegal_o (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    logic [38:0] obs;
    assign obs = {valid_o, stall_o, illegal_o, ALUCtrl_o, result_o};

    function automatic logic [38:0] exp_o(input logic v, input logic s, input logic il,
                                          input logic [3:0] c, input logic [31:0] r);
        return {v, s, il, c, r};
    endfunction

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b);
        valid_i  = 1'b1;
        ALUOp_i  = op;
        funct3_i = f3;
        funct7_i = f7;
        rs1_i    = a;
        rs2_i    = b;
    endtask

    task automatic test_reset;
        drive(2'b00, 3'b000, 7'h00, 32'd1, 32'd2);
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (obs !== exp_o(1'b0, 1'b0, 1'b0, 4'b0000, 32'd0))
                $display("FAIL reset_%0d got %h want %h", i, obs, exp_o(1'b0, 1'b0, 1'b0, 4'b0000, 32'd0));
            else passed++;
        end
        rst_i = 1'b1;
        tick();
        total++;
        if (obs !== exp_o(1'b1, 1'b0, 1'b0, 4'b0010, 32'd3))
            $display("FAIL first_accept got %h want %h", obs, exp_o(1'b1, 1'b0, 1'b0, 4'b0010, 32'd3));
        else passed++;
        valid_i = 1'b0;
        tick();
        total++;
        if (obs !== exp_o(1'b0, 1'b0, 1'b0, 4'b0010, 32'd3))
            $display("FAIL hold_after_pulse got %h want %h", obs, exp_o(1'b0, 1'b0, 1'b0, 4'b0010, 32'd3));
        else passed++;
    endtask

    task automatic test_sub_sra;
        drive(2'b10, 3'b000, 7'b0100000, 32'd5, 32'd7);
        tick();
        total++;
        if (obs !== exp_o(1'b1, 1'b0, 1'b0, 4'b0110, 32'hFFFF_FFFE))
            $display("FAIL sub got %h want %h", obs, exp_o(1'b1, 1'b0, 1'b0, 4'b0110, 32'hFFFF_FFFE));
        else passed++;
        drive(2'b11, 3'b101, 7'b0100000, 32'h8000_0000, 32'd4);
        tick();
        total++;
        if (obs !== exp_o(1'b1, 1'b0, 1'b0, 4'b1000, 32'hF800_0000))
            $display("FAIL srai got %h want %h", obs, exp_o(1'b1, 1'b0, 1'b0, 4'b1000, 32'hF800_0000));
        else passed++;
        valid_i = 1'b0;
    endtask

    task automatic test_decode;
        drive(2'b11, 3'b000, 7'b0100000, 32'd7, 32'd8);
        tick();
        total++;
        if (obs !== exp_o(1'b1, 1'b0, 1'b0, 4'b0010, 32'd15))
            $display("FAIL addi_f7_ignored got %h want %h", obs, exp_o(1'b1, 1'b0, 1'b0, 4'b0010, 32'd15));
        else passed++;
        drive(2'b10, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'd1);
        tick();
        total++;
        if (obs !== exp_o(1'b1, 1'b0, 1'b0, 4'b1001, 32'd1))
            $display("FAIL slt got %h want %h", obs, exp_o(1'b1, 1'b0, 1'b0, 4'b1001, 32'd1));
        else passed++;
        drive(2'b10, 3'b011, 7'h00, 32'hFFFF_FFFF, 32'd1);
        tick();
        total++;
        if (obs !== exp_o(1'b1, 1'b0, 1'b0, 4'b1010, 32'd0))
            $display("FAIL sltu got %h want %h", obs, exp_o(1'b1, 1'b0, 1'b0, 4'b1010, 32'd0));
        else passed++;
        drive(2'b11, 3'b001, 7'h00, 32'd1, 32'd35);
        tick();
        total++;
        if (obs !== exp_o(1'b1, 1'b0, 1'b0, 4'b0011, 32'd8))
            $display("FAIL slli_shamt got %h want %h", obs, exp_o(1'b1, 1'b0, 1'b0, 4'b0011, 32'd8));
        else passed++;
        drive(2'b11, 3'b001, 7'b0100000, 32'd1, 32'd2);
        tick();
        total++;
        if (obs !== exp_o(1'b1, 1'b0, 1'b1, 4'b1111, 32'd0))
            $display("FAIL slli_bad_f7 got %h want %h", obs, exp_o(1'b1, 1'b0, 1'b1, 4'b1111, 32'd0));
        else passed++;
        drive(2'b10, 3'b000, 7'b0000010, 32'd1, 32'd2);
        tick();
        total++;
        if (obs !== exp_o(1'b1, 1'b0, 1'b1, 4'b1111, 32'd0))
            $display("FAIL r_bad_f7 got %h want %h", obs, exp_o(1'b1, 1'b0, 1'b1, 4'b1111, 32'd0));
        else passed++;
        drive(2'b10, 3'b110, 7'h00, 32'h0000_00F0, 32'h0000_000F);
        tick();
        total++;
        if (obs !== exp_o(1'b1, 1'b0, 1'b0, 4'b0001, 32'h0000_00FF))
            $display("FAIL or_after_illegal got %h want %h", obs, exp_o(1'b1, 1'b0, 1'b0, 4'b0001, 32'h0000_00FF));
        else passed++;
        valid_i = 1'b0;
    endtask

    task automatic test_mul;
        drive(2'b10, 3'b000, 7'b0000001, 32'hFFFF_FFFF, 32'd3);
        tick();
        valid_i = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            total++;
            if ({valid_o, stall_o} !== 2'b01)
                $display("FAIL mul_stall_T+%0d got v=%b s=%b want v=0 s=1", k, valid_o, stall_o);
            else passed++;
            if (k == 5) drive(2'b00, 3'b000, 7'h00, 32'd9, 32'd9);
            else        valid_i = 1'b0;
            tick();
        end
        total++;
        if (obs !== exp_o(1'b1, 1'b0, 1'b0, 4'b0111, 32'hFFFF_FFFD))
            $display("FAIL mul_done got %h want %h", obs, exp_o(1'b1, 1'b0, 1'b0, 4'b0111, 32'hFFFF_FFFD));
        else passed++;
        tick();
        total++;
        if ({valid_o, stall_o} !== 2'b00)
            $display("FAIL mul_dropped_add got v=%b s=%b want v=0 s=0", valid_o, stall_o);
        else passed++;
    endtask

    task automatic test_div_special;
        drive(2'b10, 3'b100, 7'b0000001, 32'd10, 32'd0);
        tick();
        total++;
        if (obs !== exp_o(1'b1, 1'b0, 1'b0, 4'b1011, 32'hFFFF_FFFF))
            $display("FAIL div_by_zero got %h want %h", obs, exp_o(1'b1, 1'b0, 1'b0, 4'b1011, 32'hFFFF_FFFF));
        else passed++;
        drive(2'b10, 3'b110, 7'b0000001, 32'd10, 32'd0);
        tick();
        total++;
        if (obs !== exp_o(1'b1, 1'b0, 1'b0, 4'b1101, 32'd10))
            $display("FAIL rem_by_zero got %h want %h", obs, exp_o(1'b1, 1'b0, 1'b0, 4'b1101, 32'd10));
        else passed++;
        drive(2'b10, 3'b100, 7'b0000001, 32'h8000_0000, 32'hFFFF_FFFF);
        tick();
        total++;
        if (obs !== exp_o(1'b1, 1'b0, 1'b0, 4'b1011, 32'h8000_0000))
            $display("FAIL div_ovf got %h want %h", obs, exp_o(1'b1, 1'b0, 1'b0, 4'b1011, 32'h8000_0000));
        else passed++;
        drive(2'b10, 3'b110, 7'b0000001, 32'h8000_0000, 32'hFFFF_FFFF);
        tick();
        total++;
        if (obs !== exp_o(1'b1, 1'b0, 1'b0, 4'b1101, 32'd0))
            $display("FAIL rem_ovf got %h want %h", obs, exp_o(1'b1, 1'b0, 1'b0, 4'b1101, 32'd0));
        else passed++;
        drive(2'b10, 3'b101, 7'b0000001, 32'd5, 32'd0);
        tick();
        total++;
        if (obs !== exp_o(1'b1, 1'b0, 1'b0, 4'b1100, 32'hFFFF_FFFF))
            $display("FAIL divu_by_zero got %h want %h", obs, exp_o(1'b1, 1'b0, 1'b0, 4'b1100, 32'hFFFF_FFFF));
        else passed++;
        drive(2'b10, 3'b111, 7'b0000001, 32'd5, 32'd0);
        tick();
        total++;
        if (obs !== exp_o(1'b1, 1'b0, 1'b0, 4'b1110, 32'd5))
            $display("FAIL remu_by_zero got %h want %h", obs, exp_o(1'b1, 1'b0, 1'b0, 4'b1110, 32'd5));
        else passed++;
        valid_i = 1'b0;
    endtask

    // Each op is issued in the completion cycle of the previous one (back to back).
    task automatic test_div_iter;
        drive(2'b10, 3'b100, 7'b0000001, 32'hFFFF_FFF9, 32'd2);
        tick();
        valid_i = 1'b0;
        total++;
        if ({valid_o, stall_o} !== 2'b01)
            $display("FAIL div_stall got v=%b s=%b want v=0 s=1", valid_o, stall_o);
        else passed++;
        repeat (32) tick();
        total++;
        if (obs !== exp_o(1'b1, 1'b0, 1'b0, 4'b1011, 32'hFFFF_FFFD))
            $display("FAIL div_neg got %h want %h", obs, exp_o(1'b1, 1'b0, 1'b0, 4'b1011, 32'hFFFF_FFFD));
        else passed++;
        drive(2'b10, 3'b110, 7'b0000001, 32'hFFFF_FFF9, 32'd2);
        tick();
        valid_i = 1'b0;
        total++;
        if ({valid_o, stall_o} !== 2'b01)
            $display("FAIL rem_b2b_stall got v=%b s=%b want v=0 s=1", valid_o, stall_o);
        else passed++;
        repeat (32) tick();
        total++;
        if (obs !== exp_o(1'b1, 1'b0, 1'b0, 4'b1101, 32'hFFFF_FFFF))
            $display("FAIL rem_neg got %h want %h", obs, exp_o(1'b1, 1'b0, 1'b0, 4'b1101, 32'hFFFF_FFFF));
        else passed++;
        drive(2'b10, 3'b111, 7'b0000001, 32'd7, 32'd2);
        tick();
        valid_i = 1'b0;
        repeat (32) tick();
        total++;
        if (obs !== exp_o(1'b1, 1'b0, 1'b0, 4'b1110, 32'd1))
            $display("FAIL remu got %h want %h", obs, exp_o(1'b1, 1'b0, 1'b0, 4'b1110, 32'd1));
        else passed++;
        drive(2'b10, 3'b101, 7'b0000001, 32'd100, 32'd7);
        tick();
        valid_i = 1'b0;
        repeat (32) tick();
        total++;
        if (obs !== exp_o(1'b1, 1'b0, 1'b0, 4'b1100, 32'd14))
            $display("FAIL divu got %h want %h", obs, exp_o(1'b1, 1'b0, 1'b0, 4'b1100, 32'd14));
        else passed++;
        tick();
    endtask

    task automatic test_flush;
        int bad;
        drive(2'b10, 3'b000, 7'b0000001, 32'd3, 32'd4);
        tick();
        valid_i = 1'b0;
        repeat (9) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        total++;
        if ({valid_o, stall_o} !== 2'b00)
            $display("FAIL flush_busy got v=%b s=%b want v=0 s=0", valid_o, stall_o);
        else passed++;
        drive(2'b00, 3'b000, 7'h00, 32'd1, 32'd2);
        tick();
        valid_i = 1'b0;
        total++;
        if (obs !== exp_o(1'b1, 1'b0, 1'b0, 4'b0010, 32'd3))
            $display("FAIL add_after_flush got %h want %h", obs, exp_o(1'b1, 1'b0, 1'b0, 4'b0010, 32'd3));
        else passed++;
        bad = 0;
        for (int i = 0; i < 35; i++) begin
            tick();
            if (valid_o !== 1'b0 || stall_o !== 1'b0) bad++;
        end
        total++;
        if (bad != 0)
            $display("FAIL flushed_mul_leak got %0d busy/valid cycles want 0", bad);
        else passed++;
        drive(2'b00, 3'b000, 7'h00, 32'd4, 32'd4);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        valid_i = 1'b0;
        total++;
        if ({valid_o, stall_o, result_o} !== {2'b00, 32'd3})
            $display("FAIL flush_idle got v=%b s=%b r=%h want v=0 s=0 r=00000003", valid_o, stall_o, result_o);
        else passed++;
        drive(2'b10, 3'b001, 7'b0000001, 32'd6, 32'd7);
        tick();
        valid_i = 1'b0;
        total++;
        if (obs !== exp_o(1'b1, 1'b0, 1'b1, 4'b1111, 32'd0))
            $display("FAIL illegal_m got %h want %h", obs, exp_o(1'b1, 1'b0, 1'b1, 4'b1111, 32'd0));
        else passed++;
    endtask

    initial begin
        test_reset();
        test_sub_sra();
        test_decode();
        test_mul();
        test_div_special();
        test_div_iter();
        test_flush();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_muldiv.md
Name: alu_ctrl_muldiv

Overview:
Next-generation ALU control for the EX stage.
- Decodes ALUOp_i/funct3_i/funct7_i into a 4-bit ALU operation covering full RV32I R/I-type arithmetic plus the M-extension MUL/DIV/DIVU/REM/REMU.
- Executes single-cycle ops with a registered result.
- Runs MUL/DIV/REM in an iterative radix-2 unit, stalling the pipeline while busy.

Parameters:
- XLEN, 32, operand/result width (power of two, ≥8)
- ENABLE_M, 1, when 0 every funct7=0000001 encoding decodes ILLEGAL

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-low reset
- valid_i  in  1  instruction present this cycle
- flush_i  in  1  kill in-flight/incoming op
- ALUOp_i  in  2  00 load/store add, 01 branch sub, 10 R-type, 11 I-type
- funct3_i  in  3  instruction funct3
- funct7_i  in  7  instruction funct7
- rs1_i  in  XLEN  operand A
- rs2_i  in  XLEN  operand B or immediate
- stall_o  out  1  unit busy; upstream must hold the next instruction
- valid_o  out  1  one-cycle pulse: result_o/ALUCtrl_o/illegal_o valid
- result_o  out  XLEN  result
- ALUCtrl_o  out  4  decoded operation code of the completed op
- illegal_o  out  1  completed op was an undefined encoding

Behaviour:
- Reset (rst_i=0 at a clock edge): state IDLE, iteration counter 0, valid_o=0, stall_o=0, result_o=0, ALUCtrl_o=0000, illegal_o=0. Reset mid-operation abandons the op; no valid_o is produced.
- Codes: AND 0000, OR 0001, ADD 0010, SLL 0011, XOR 0100, SRL 0101, SUB 0110, MUL 0111, SRA 1000, SLT 1001, SLTU 1010, DIV 1011, DIVU 1100, REM 1101, REMU 1110, ILLEGAL 1111.
- Decode by ALUOp_i:
  - 00: ADD.
  - 01: SUB.
  - 10, funct7=0000000: f3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - 10, funct7=0100000: f3 000 SUB, 101 SRA; other f3 ILLEGAL.
  - 10, funct7=0000001: f3 000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU; f3 001/010/011 ILLEGAL.
  - 10, any other funct7: ILLEGAL.
  - 11: funct3 as R-type with funct7 ignored, except: f3 001 requires funct7=0000000; f3 101 uses funct7 0000000→SRL, 0100000→SRA; anything else ILLEGAL.
- Shift amount: rs2_i[$clog2(XLEN)-1:0]. MUL returns the low XLEN bits.
- Accept: state IDLE & valid_i & !flush_i at edge T.
- Single-cycle ops, ILLEGAL, and division special cases: valid_o=1 in cycle T+1 with the registered result. ILLEGAL gives result_o=0, illegal_o=1.
- Division special cases:
  - divisor 0: DIV/DIVU quotient all-ones; REM/REMU = rs1_i.
  - signed overflow (most-negative / −1): DIV = most-negative; REM = 0.
- Iterative ops (MUL, and DIV/REM otherwise):
  - FSM IDLE→BUSY; counter loaded with XLEN.
  - Cycles T+1..T+XLEN: stall_o=1, one shift-add (mul) or restoring-subtract (div) step per cycle.
  - Signed DIV/REM operate on magnitudes. Quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1). Sign fix-up is applied on the final step.
  - Cycle T+XLEN+1: valid_o=1, stall_o=0, state IDLE. A new valid_i may be accepted in that same cycle.
  - Total latency XLEN+1.
- valid_i while BUSY is ignored; the instruction is dropped and produces no later valid_o.
- flush_i:
  - In BUSY: next state IDLE, no valid_o, stall_o=0 in the following cycle.
  - In IDLE together with valid_i: flush wins, no accept.
  - When valid_o is already registered: the pulse is still delivered.
- valid_o is low in every cycle without a completion. result_o/ALUCtrl_o hold their last value between completions.

Decomposition:
- Package alu_pkg holds:
  - ALU code localparams (4-bit) and ALUOp encodings.
  - funct7 constants: 0000000, 0100000, 0000001.
- Sub-module alu_iter_muldiv (parametrised by XLEN): iterative multiply/divide datapath, counter and sign fix-up; start/flush in, done/result out.
- The top level holds decode, the single-cycle ALU, the FSM and the output registers.

Test Plan:
- rst_i=0 for 2 cycles with valid_i=1 → valid_o=0, stall_o=0, result_o=0, ALUCtrl_o=0000; first op accepted only after rst_i=1.
- ALUOp=10 f3=000 f7=0100000, rs1=5, rs2=7 → next cycle valid_o=1, result_o=0xFFFFFFFE, ALUCtrl_o=0110; ALUOp=11 f3=101 f7=0100000, rs1=0x80000000, rs2=4 → result_o=0xF8000000, ALUCtrl_o=1000.
- MUL rs1=0xFFFFFFFF, rs2=3 → stall_o=1 for cycles T+1..T+32, valid_o at T+33 with result_o=0xFFFFFFFD, ALUCtrl_o=0111; an ADD presented at T+5 produces no valid_o.
- DIV rs1=10, rs2=0 → valid_o at T+1, result_o=0xFFFFFFFF; REM same operands → 10; DIV 0x80000000/0xFFFFFFFF → 0x80000000 at T+1; REM same → 0.
- DIV rs1=−7, rs2=2 → result_o=0xFFFFFFFD at T+33; REM → 0xFFFFFFFF; REMU 7, 2 → 1.
- flush_i at T+10 of a MUL → no valid_o, stall_o=0 at T+11; ADD 1+2 accepted at T+11 → valid_o at T+12, result_o=3. ALUOp=10 f3=001 f7=0000001 → illegal_o=1, ALUCtrl_o=1111, result_o=0.
